// File: rtl/rob_alloc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rob_alloc_ctrl_pkg                                           |
// | Description : Shared sizing constants and FSM state encoding for the ROB   |
// |               allocation / exception-recovery controller.                  |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rob_alloc_ctrl_pkg;

  localparam int          DEF_ROB_SLOTS    = 16;
  localparam int          DEF_ROB_IDX_BITS = 4;
  localparam int          DEF_ARCH_BITS    = 32;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_2000;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } rob_state_e;

endpackage
`default_nettype wire

// File: rtl/rob_alloc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rob_alloc_ctrl_if                                            |
// | Description : Bundle between decode/commit logic (master) and the ROB      |
// |               allocation controller (slave).                               |
// | Ports       : alloc handshake, commit/exception inputs, flush/redirect     |
// |               outputs, exception record, occupancy status.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rob_alloc_ctrl_if
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int ROB_IDX_BITS = DEF_ROB_IDX_BITS,
  parameter int ARCH_BITS    = DEF_ARCH_BITS
);

  logic                    allocValid;
  logic                    allocReady;
  logic [ROB_IDX_BITS-1:0] allocIdx;

  logic                    commitValid;
  logic                    commitExcept;
  logic [ARCH_BITS-1:0]    commitPc;
  logic [ARCH_BITS-1:0]    commitAddr;
  logic [ARCH_BITS-1:0]    commitType;

  logic                    robClear;
  logic                    redirect;
  logic [ARCH_BITS-1:0]    redirectPc;

  logic [ARCH_BITS-1:0]    excPc;
  logic [ARCH_BITS-1:0]    excAddr;
  logic [ARCH_BITS-1:0]    excType;

  logic [ROB_IDX_BITS-1:0] headIdx;
  logic [ROB_IDX_BITS:0]   count;
  logic                    full;
  logic                    empty;

  modport master (
    output allocValid, commitValid, commitExcept, commitPc, commitAddr, commitType,
    input  allocReady, allocIdx, robClear, redirect, redirectPc,
           excPc, excAddr, excType, headIdx, count, full, empty
  );

  modport slave (
    input  allocValid, commitValid, commitExcept, commitPc, commitAddr, commitType,
    output allocReady, allocIdx, robClear, redirect, redirectPc,
           excPc, excAddr, excType, headIdx, count, full, empty
  );

endinterface
`default_nettype wire

// File: rtl/rob_alloc_ctrl_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rob_ptr                                                      |
// | Description : Wrap-around ROB slot pointer with clear and increment.       |
// |               Wraps naturally at 2**IDX_BITS.                              |
// | Ports       : clk, rst  - clock, synchronous active-high reset             |
// |               i_clr     - force pointer to zero (wins over i_inc)          |
// |               i_inc     - advance pointer by one                           |
// |               o_ptr     - current pointer value                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rob_ptr #(
  parameter int IDX_BITS = 4
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_clr,
  input  wire logic                i_inc,
  output logic      [IDX_BITS-1:0] o_ptr
);

  logic [IDX_BITS-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + IDX_BITS'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rob_alloc_ctrl                                               |
// | Description : ROB slot allocation, in-order commit bookkeeping and         |
// |               exception recovery (NORMAL -> FLUSH -> RECOVER -> NORMAL).   |
// | Ports       : clk, rst - clock, synchronous active-high reset              |
// |               bus      - rob_alloc_ctrl_if.slave: alloc handshake, commit  |
// |                          inputs, flush/redirect, exception record, status |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int                   ROB_SLOTS    = DEF_ROB_SLOTS,
  parameter int                   ROB_IDX_BITS = DEF_ROB_IDX_BITS,
  parameter int                   ARCH_BITS    = DEF_ARCH_BITS,
  parameter logic [ARCH_BITS-1:0] EXC_VECTOR   = ARCH_BITS'(DEF_EXC_VECTOR)
) (
  input wire logic        clk,
  input wire logic        rst,
  rob_alloc_ctrl_if.slave bus
);

  localparam logic [ROB_IDX_BITS:0] C_FULL_COUNT = (ROB_IDX_BITS+1)'(ROB_SLOTS);

  rob_state_e              r_state;
  rob_state_e              w_next_state;
  logic [ROB_IDX_BITS:0]   r_count;
  logic [ROB_IDX_BITS-1:0] w_head_idx;
  logic [ROB_IDX_BITS-1:0] w_tail_idx;
  logic [ARCH_BITS-1:0]    r_exc_pc;
  logic [ARCH_BITS-1:0]    r_exc_addr;
  logic [ARCH_BITS-1:0]    r_exc_type;

  logic                    w_normal;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_except;
  logic                    w_alloc_ready;
  logic                    w_alloc;
  logic                    w_commit;
  logic                    w_rob_clear;
  logic                    w_redirect;
  logic [ARCH_BITS-1:0]    w_redirect_pc;

  assign w_normal = (r_state == ST_NORMAL);
  assign w_full   = (r_count == C_FULL_COUNT);
  assign w_empty  = (r_count == '0);

  // Exceptions are only honoured in NORMAL; FLUSH/RECOVER ignore commit inputs.
  assign w_except = w_normal && bus.commitValid && bus.commitExcept;

  // An excepting commit blocks allocation in the same cycle so no slot is
  // handed out just before the ROB is wiped.
  assign w_alloc_ready = w_normal && !w_full && !(bus.commitValid && bus.commitExcept);
  assign w_alloc       = bus.allocValid && w_alloc_ready;

  // A commit while empty is a protocol error and is dropped (no underflow).
  assign w_commit = w_normal && bus.commitValid && !bus.commitExcept && !w_empty;

  rob_ptr #(.IDX_BITS(ROB_IDX_BITS)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_except),
    .i_inc (w_commit),
    .o_ptr (w_head_idx)
  );

  rob_ptr #(.IDX_BITS(ROB_IDX_BITS)) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_except),
    .i_inc (w_alloc),
    .o_ptr (w_tail_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_rob_clear   = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    case (r_state)
      ST_NORMAL: begin
        if (w_except) begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_rob_clear   = 1'b1;
        w_redirect    = 1'b1;
        w_redirect_pc = EXC_VECTOR;
        w_next_state  = ST_RECOVER;
      end
      ST_RECOVER: begin
        w_next_state = ST_NORMAL;
      end
      default: begin
        w_next_state = ST_NORMAL;
      end
    endcase
  end

  // Simultaneous alloc and commit cancel out; count only moves on one of them.
  always_ff @(posedge clk) begin
    if (rst || w_except) begin
      r_count <= '0;
    end else if (w_alloc && !w_commit) begin
      r_count <= r_count + (ROB_IDX_BITS+1)'(1);
    end else if (!w_alloc && w_commit) begin
      r_count <= r_count - (ROB_IDX_BITS+1)'(1);
    end
  end

  // Exception record holds until the next exception.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_pc   <= '0;
      r_exc_addr <= '0;
      r_exc_type <= '0;
    end else if (w_except) begin
      r_exc_pc   <= bus.commitPc;
      r_exc_addr <= bus.commitAddr;
      r_exc_type <= bus.commitType;
    end
  end

  assign bus.allocReady = w_alloc_ready;
  assign bus.allocIdx   = w_tail_idx;
  assign bus.robClear   = w_rob_clear;
  assign bus.redirect   = w_redirect;
  assign bus.redirectPc = w_redirect_pc;
  assign bus.excPc      = r_exc_pc;
  assign bus.excAddr    = r_exc_addr;
  assign bus.excType    = r_exc_type;
  assign bus.headIdx    = w_head_idx;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rob_alloc_ctrl                                            |
// | Description : Self-checking bench for rob_alloc_ctrl: table of directed    |
// |               vectors plus hand-written multi-cycle sequences.             |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rob_alloc_ctrl;

  logic clk;
  logic rst;

  int n_pass;
  int n_total;

  rob_alloc_ctrl_if bus ();

  rob_alloc_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic av;
    logic cv;
    logic ce;
    logic e_rdy;
    int   e_idx;
    int   e_cnt;
    int   e_head;
    logic e_full;
    logic e_empty;
    logic e_clr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic cv, input logic ce);
    bus.allocValid   = av;
    bus.commitValid  = cv;
    bus.commitExcept = ce;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    bus.commitPc   = '0;
    bus.commitAddr = '0;
    bus.commitType = '0;

    //          av    cv    ce    rdy   idx cnt head full  empty clr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  0,  0,  1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  1,  0,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2,  2,  0,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3,  2,  1,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3,  1,  2,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3,  0,  3,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3,  0,  3,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3,  0,  3,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0,  0,  0,  1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0,  0,  0,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  0,  0,  1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  1,  0,  1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_ready",    64'(bus.allocReady), 64'd1);
    chk("rst_idx",      64'(bus.allocIdx),   64'd0);
    chk("rst_head",     64'(bus.headIdx),    64'd0);
    chk("rst_count",    64'(bus.count),      64'd0);
    chk("rst_empty",    64'(bus.empty),      64'd1);
    chk("rst_full",     64'(bus.full),       64'd0);
    chk("rst_clear",    64'(bus.robClear),   64'd0);
    chk("rst_redirect", 64'(bus.redirect),   64'd0);
    chk("rst_excpc",    64'(bus.excPc),      64'd0);
    chk("rst_excaddr",  64'(bus.excAddr),    64'd0);
    chk("rst_exctype",  64'(bus.excType),    64'd0);

    // Table: alloc/commit mix, commit-while-empty, exception in NORMAL,
    // exception inputs ignored in FLUSH/RECOVER.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].cv, vecs[i].ce);
      bus.commitPc = 32'h500 + 32'(i);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.allocReady), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_idx", i),   64'(bus.allocIdx),   64'(vecs[i].e_idx));
      chk($sformatf("v%0d_count", i), 64'(bus.count),      64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_head", i),  64'(bus.headIdx),    64'(vecs[i].e_head));
      chk($sformatf("v%0d_full", i),  64'(bus.full),       64'(vecs[i].e_full));
      chk($sformatf("v%0d_empty", i), 64'(bus.empty),      64'(vecs[i].e_empty));
      chk($sformatf("v%0d_clear", i), 64'(bus.robClear),   64'(vecs[i].e_clr));
      chk($sformatf("v%0d_redir", i), 64'(bus.redirect),   64'(vecs[i].e_clr));
      chk($sformatf("v%0d_rpc", i),   64'(bus.redirectPc),
          vecs[i].e_clr ? 64'h2000 : 64'd0);
    end
    chk("tbl_excpc_held", 64'(bus.excPc), 64'h507);

    // Fill to full: 16 grants, indices 0..15, then blocked.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0);
      #1;
      chk($sformatf("fill%0d_idx", i),   64'(bus.allocIdx),   64'(i));
      chk($sformatf("fill%0d_ready", i), 64'(bus.allocReady), 64'd1);
    end
    @(negedge clk);
    #1;
    chk("full_count", 64'(bus.count),      64'd16);
    chk("full_flag",  64'(bus.full),       64'd1);
    chk("full_ready", 64'(bus.allocReady), 64'd0);
    // Full with commit: still no grant this cycle.
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("fullcommit_ready", 64'(bus.allocReady), 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("fullcommit_head",  64'(bus.headIdx),    64'd1);
    chk("fullcommit_count", 64'(bus.count),      64'd15);
    chk("wrap_ready",       64'(bus.allocReady), 64'd1);
    chk("wrap_idx",         64'(bus.allocIdx),   64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("wrap_count", 64'(bus.count), 64'd16);

    // Steady state: count 5, 20 cycles of alloc+commit.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0);
      #1;
      chk($sformatf("steady%0d_count", i), 64'(bus.count), 64'd5);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("steady_count_end", 64'(bus.count),    64'd5);
    chk("steady_head",      64'(bus.headIdx),  64'd4);
    chk("steady_tail",      64'(bus.allocIdx), 64'd9);

    // Exception record, flush and recover.
    bus.commitPc   = 32'h100;
    bus.commitAddr = 32'h44;
    bus.commitType = 32'd8;
    drive(1'b0, 1'b1, 1'b1);
    #1;
    chk("exc_ready_blocked", 64'(bus.allocReady), 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    bus.commitPc = 32'hDEAD;
    #1;
    chk("exc_clear",   64'(bus.robClear),   64'd1);
    chk("exc_redir",   64'(bus.redirect),   64'd1);
    chk("exc_rpc",     64'(bus.redirectPc), 64'h2000);
    chk("exc_pc",      64'(bus.excPc),      64'h100);
    chk("exc_addr",    64'(bus.excAddr),    64'h44);
    chk("exc_type",    64'(bus.excType),    64'd8);
    chk("exc_count",   64'(bus.count),      64'd0);
    chk("flush_ready", 64'(bus.allocReady), 64'd0);
    @(negedge clk);
    #1;
    chk("recover_ready", 64'(bus.allocReady), 64'd0);
    chk("recover_clear", 64'(bus.robClear),   64'd0);
    chk("recover_redir", 64'(bus.redirect),   64'd0);
    chk("recover_rpc",   64'(bus.redirectPc), 64'd0);
    @(negedge clk);
    #1;
    chk("post_ready", 64'(bus.allocReady), 64'd1);
    chk("post_idx",   64'(bus.allocIdx),   64'd0);
    chk("post_count", 64'(bus.count),      64'd0);
    chk("post_excpc", 64'(bus.excPc),      64'h100);

    // Reset during FLUSH.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1);
    bus.commitPc = 32'h300;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("rf_in_flush", 64'(bus.robClear), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rf_clear", 64'(bus.robClear),   64'd0);
    chk("rf_redir", 64'(bus.redirect),   64'd0);
    chk("rf_ready", 64'(bus.allocReady), 64'd1);
    chk("rf_head",  64'(bus.headIdx),    64'd0);
    chk("rf_idx",   64'(bus.allocIdx),   64'd0);
    chk("rf_count", 64'(bus.count),      64'd0);
    @(negedge clk);
    #1;
    chk("rf_no_pulse", 64'(bus.robClear), 64'd0);

    // Reset wins over a simultaneous exception.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1);
    bus.commitPc = 32'h400;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("rstexc_clear", 64'(bus.robClear), 64'd0);
    chk("rstexc_excpc", 64'(bus.excPc),    64'd0);
    chk("rstexc_ready", 64'(bus.allocReady), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_alloc_ctrl.md
ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

Interface
REQ-001 Parameter ROB_SLOTS, default 16, number of ROB entries; power of two.
REQ-002 Parameter ROB_IDX_BITS, default 4, log2(ROB_SLOTS).
REQ-003 Parameter ARCH_BITS, default 32, datapath width.
REQ-004 Parameter EXC_VECTOR, default 32'h0000_2000, exception handler PC.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 allocValid  in  1  decode requests one ROB slot this cycle.
REQ-008 allocReady  out  1  slot available; handshake = allocValid && allocReady.
REQ-009 allocIdx  out  ROB_IDX_BITS  index granted on handshake (current tail).
REQ-010 commitValid  in  1  ROB head entry retires this cycle.
REQ-011 commitExcept  in  1  retiring entry carries an exception; qualified by commitValid.
REQ-012 commitPc, commitAddr, commitType  in  ARCH_BITS each  retiring entry's PC, faulting address, exception type.
REQ-013 robClear  out  1  clears ROB and flushes pipeline.
REQ-014 redirect  out  1  fetch redirect strobe.
REQ-015 redirectPc  out  ARCH_BITS  fetch target when redirect=1.
REQ-016 excPc, excAddr, excType  out  ARCH_BITS each  latched exception record.
REQ-017 headIdx  out  ROB_IDX_BITS  oldest in-flight slot.
REQ-018 count  out  ROB_IDX_BITS+1  occupied slots, 0..ROB_SLOTS.
REQ-019 full, empty  out  1 each  count==ROB_SLOTS / count==0.

Function
REQ-020 FSM states NORMAL, FLUSH, RECOVER; only NORMAL permits allocation or commit.
REQ-021 allocReady = (state==NORMAL) && !full && !(commitValid && commitExcept), combinational.
REQ-022 allocIdx = tailIdx; on handshake, tailIdx <= (tailIdx+1) mod ROB_SLOTS.
REQ-023 In NORMAL, a commit without exception advances headIdx by 1 mod ROB_SLOTS.
REQ-024 count: +1 on handshake only, -1 on non-exception commit only, unchanged when both occur in the same cycle.
REQ-025 A commit while empty is a protocol error; count and headIdx stay unchanged (no underflow).
REQ-026 A handshake while full is impossible by REQ-021; full with a simultaneous commit still blocks allocation that cycle.
REQ-027 NORMAL -> FLUSH when commitValid && commitExcept; at that edge latch excPc/excAddr/excType from the commit inputs and zero headIdx, tailIdx, count.
REQ-028 In FLUSH (exactly 1 cycle): robClear=1, redirect=1, redirectPc=EXC_VECTOR; next state RECOVER.
REQ-029 In RECOVER (exactly 1 cycle): robClear=0, redirect=0, allocReady=0; next state NORMAL.
REQ-030 Exception-to-first-allocation latency is 3 cycles after the excepting commit cycle.
REQ-031 commitValid and commitExcept are ignored in FLUSH and RECOVER.
REQ-032 excPc/excAddr/excType hold their value until the next exception.
REQ-033 robClear, redirect = 0 and redirectPc = 0 in NORMAL and RECOVER.

Reset
REQ-034 rst has priority over all other inputs, including a simultaneous exception.
REQ-035 After reset: state NORMAL, headIdx=tailIdx=count=0, empty=1, full=0, allocReady=1 (when commitExcept=0), robClear=0, redirect=0, excPc=excAddr=excType=0.
REQ-036 rst asserted in FLUSH or RECOVER returns to NORMAL at the next edge; no further robClear pulse.

Structure
REQ-037 ROB_SLOTS, ROB_IDX_BITS, ARCH_BITS, EXC_VECTOR, and the state encoding live in the shared proc package.
REQ-038 One sub-module, rob_ptr: a wrap-around pointer with clear and increment; instantiated for head and tail.
REQ-039 The FSM, count, and exception record stay in rob_alloc_ctrl; there is no combinational path from commit inputs to count.

Verification
REQ-040 Reset, then allocValid=1 for 16 cycles with no commits -> allocIdx 0..15, count=16, full=1, allocReady=0 on cycle 17.
REQ-041 Full ROB, allocValid=1 and commitValid=1 same cycle -> no grant, headIdx=1, count=15; next cycle grant with allocIdx=0 (wrap).
REQ-042 count=5, simultaneous handshake and commit for 20 cycles -> count stays 5; headIdx and tailIdx wrap past 15.
REQ-043 commitValid=1, commitExcept=1, commitPc=32'h100, commitAddr=32'h44, commitType=8 -> next cycle robClear=1, redirect=1, redirectPc=32'h2000, excPc=32'h100; one RECOVER cycle with allocReady=0; then NORMAL with count=0.
REQ-044 rst asserted during FLUSH -> next cycle NORMAL, robClear=0, all pointers 0.
REQ-045 commitValid=1 while empty -> count stays 0 and headIdx is unchanged.
